uart_rx_axilite: RTL and testbench

UART receiver with an AXI-Lite read-only slave port and a small receive FIFO. It is the receive-side partner of the AXI-Lite UART transmitter: it deserialises the `rx` pin and buffers bytes until the CPU reads them. It uses the same register-port style and bit-timing parameters as the transmitter, so the two sit side by side on the peripheral bus.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx.sv | 108 ++++++++++
 rtl/uart_rx_axilite.sv | 133 +++++++++++++
 tb/tb_uart_rx_axilite.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the AXI-Lite UART receiver: register map,
// STATUS bit positions and FSM encodings.
package uart_pkg;

  // Register byte offsets (decode uses bits [3:2])
  localparam logic [3:0] UART_RXDATA = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;

  // STATUS register bit indices
  localparam int ST_NONEMPTY = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_OVR      = 2;
  localparam int ST_FERR     = 3;

  // Serial receiver states
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // AXI-Lite read channel states
  typedef enum logic {
    R_IDLE,
    R_RESP
  } bus_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 serial deserialiser: 2-flop synchroniser, falling-edge start
// detection, mid-bit sampling. Emits one-cycle byte / frame-error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BIT_PERIOD = 1250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  output logic       rx_ferr_o
);

  localparam logic [15:0] FULL_M1 = 16'(BIT_PERIOD - 1);
  localparam logic [15:0] HALF_M1 = 16'(BIT_PERIOD / 2 - 1);

  logic      meta_q, sync_q, prev_q;
  logic      fall;
  rx_state_e state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        valid_q, ferr_q;
  logic [7:0]  data_q;

  // Synchronise the async pin; line idles high so reset to 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign fall = prev_q & ~sync_q;

  // Receiver FSM: half-bit wait to centre, then one sample per bit period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (fall) begin
            cnt_q   <= HALF_M1;
            state_q <= RX_START;
          end
        end
        RX_START: begin
          if (cnt_q == '0) begin
            if (sync_q) begin
              state_q <= RX_IDLE;          // line back high: glitch, not a start bit
            end else begin
              cnt_q   <= FULL_M1;
              bit_q   <= '0;
              state_q <= RX_DATA;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        RX_DATA: begin
          if (cnt_q == '0) begin
            shift_q <= {sync_q, shift_q[7:1]};  // LSB arrives first
            cnt_q   <= FULL_M1;
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        RX_STOP: begin
          if (cnt_q == '0) begin
            if (sync_q) begin
              valid_q <= 1'b1;
              data_q  <= shift_q;
            end else begin
              ferr_q  <= 1'b1;
            end
            state_q <= RX_IDLE;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign rx_valid_o = valid_q;
  assign rx_data_o  = data_q;
  assign rx_ferr_o  = ferr_q;

endmodule

// File: rtl/uart_rx_axilite.sv
// UART receiver with receive FIFO, sticky overrun/frame-error flags and a
// read-only AXI-Lite slave port (RXDATA pops, STATUS read clears flags).
module uart_rx_axilite
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic        rvalid,
  input  logic        rready,
  input  logic        rx,
  output logic        rx_irq
);

  localparam int BIT_PERIOD = CLK_FREQ / BAUD;
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam logic [1:0] A_RXDATA = UART_RXDATA[3:2];
  localparam logic [1:0] A_STATUS = UART_STATUS[3:2];

  logic       rx_valid, rx_ferr;
  logic [7:0] rx_data;

  uart_rx #(.BIT_PERIOD(BIT_PERIOD)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (rx),
    .rx_valid_o (rx_valid),
    .rx_data_o  (rx_data),
    .rx_ferr_o  (rx_ferr)
  );

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          ovr_q, ferr_q;
  bus_state_e    bstate_q;
  logic          arready_q, rvalid_q;
  logic [31:0]   rdata_q, rdata_d;

  logic nonempty, full, rd_hs, rd_data_sel, rd_stat_sel, pop, push_ok, ovr_set;
  logic unused_addr_bits;

  assign unused_addr_bits = ^araddr[1:0];

  assign nonempty    = (count_q != '0);
  assign full        = (count_q == (AW+1)'(FIFO_DEPTH));
  assign rd_hs       = arready_q & arvalid;
  assign rd_data_sel = rd_hs & (araddr[3:2] == A_RXDATA);
  assign rd_stat_sel = rd_hs & (araddr[3:2] == A_STATUS);
  assign pop         = rd_data_sel & nonempty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push_ok     = rx_valid & (~full | pop);
  assign ovr_set     = rx_valid & full & ~pop;

  // FIFO storage; contents need no reset, only pointers do
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= rx_data;
  end

  // FIFO pointers, occupancy and sticky flags (set beats read-clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
      ovr_q   <= ovr_set | (ovr_q  & ~rd_stat_sel);
      ferr_q  <= rx_ferr | (ferr_q & ~rd_stat_sel);
    end
  end

  // Read data mux for the addressed register
  always_comb begin
    rdata_d = '0;
    case (araddr[3:2])
      A_RXDATA: if (nonempty) rdata_d = {23'b0, 1'b1, mem_q[rd_ptr_q]};
      A_STATUS: begin
        rdata_d[ST_NONEMPTY] = nonempty;
        rdata_d[ST_FULL]     = full;
        rdata_d[ST_OVR]      = ovr_q;
        rdata_d[ST_FERR]     = ferr_q;
      end
      default: rdata_d = '0;
    endcase
  end

  // AXI-Lite read channel: capture on AR handshake, hold until R accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bstate_q  <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (bstate_q)
        R_IDLE: begin
          if (arvalid) begin
            rdata_q   <= rdata_d;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            bstate_q  <= R_RESP;
          end
        end
        R_RESP: begin
          if (rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            bstate_q  <= R_IDLE;
          end
        end
        default: bstate_q <= R_IDLE;
      endcase
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rx_irq  = nonempty;

endmodule

// File: tb/tb_uart_rx_axilite.sv
// Directed + randomized bench for uart_rx_axilite. A short bit period keeps
// the run compact; the reference model is a byte queue plus two flags.
`timescale 1ns/1ps
module tb_uart_rx_axilite;

  localparam int BP    = 64;
  localparam int DEPTH = 4;

  logic        clk, rst;
  logic [3:0]  araddr;
  logic        arvalid, arready, rvalid, rready, rx, rx_irq;
  logic [31:0] rdata;

  int nchk  = 0;
  int npass = 0;

  logic [7:0] mq[$];
  logic       m_ovr = 1'b0;
  logic       m_ferr = 1'b0;

  uart_rx_axilite #(.CLK_FREQ(12000000), .BAUD(187500), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready), .rx(rx), .rx_irq(rx_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference: what a read of address a must return, applying its side effect
  function automatic logic [31:0] model_read(input logic [3:0] a);
    logic [31:0] r;
    r = '0;
    case (a[3:2])
      2'd0: if (mq.size() > 0) r = {23'b0, 1'b1, mq.pop_front()};
      2'd1: begin
        r = {28'b0, m_ferr, m_ovr, (mq.size() == DEPTH), (mq.size() > 0)};
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Drive the first nbits of a 10-bit 8N1 frame (start, d0..d7, stop)
  task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input int nbits);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rx = fr[i];
      repeat (BP) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    drive_frame(b, stop_ok, 10);
    rx = 1'b1;
    repeat (BP) @(negedge clk);
    if (stop_ok) begin
      if (mq.size() < DEPTH) mq.push_back(b);
      else m_ovr = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic do_read(input logic [3:0] a, input string tag);
    logic [31:0] exp;
    int n;
    exp = model_read(a);
    @(negedge clk);
    araddr  = a;
    arvalid = 1'b1;
    rready  = 1'b1;
    check({tag, "_arready"}, arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 10) begin @(negedge clk); n++; end
    check({tag, "_rvalid"}, rvalid, 1);
    check(tag, rdata, exp);
    @(negedge clk);
    rready = 1'b0;
    check({tag, "_rvalid_drop"}, rvalid, 0);
  endtask

  initial begin
    logic [31:0] sexp;
    logic        bad;
    int          nb, n;
    logic [7:0]  rb;

    rst = 1'b1; rx = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_arready", arready, 1);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_irq", rx_irq, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Empty reads and unmapped addresses
    do_read(4'h0, "empty_rxdata");
    do_read(4'h4, "empty_status");
    do_read(4'h8, "addr8");
    do_read(4'hC, "addrC");

    // Single byte
    send_byte(8'hA5, 1'b1);
    check("single_irq", rx_irq, 1);
    do_read(4'h0, "single_rxdata");
    do_read(4'h4, "single_status");
    check("single_irq_clr", rx_irq, 0);

    // Overflow: fifth byte dropped, ovr sticky until STATUS read
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    do_read(4'h4, "ovf_status");
    for (int i = 0; i < 4; i++) do_read(4'h0, "ovf_rxdata");
    do_read(4'h4, "ovf_status2");
    do_read(4'h0, "ovf_empty");

    // Frame error
    send_byte(8'h3C, 1'b0);
    do_read(4'h4, "ferr_status");
    check("ferr_irq", rx_irq, 0);
    do_read(4'h4, "ferr_status2");

    // Glitch shorter than half a bit is ignored
    rx = 1'b0;
    repeat (BP / 3) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BP) @(negedge clk);
    check("glitch_irq", rx_irq, 0);
    do_read(4'h4, "glitch_status");

    // Stalled response while a byte arrives
    fork
      send_byte(8'h5A, 1'b1);
      begin
        sexp = model_read(4'h0);
        @(negedge clk);
        araddr = 4'h0; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 10) begin @(negedge clk); n++; end
        check("stall_rvalid", rvalid, 1);
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
          if (rdata !== sexp || rvalid !== 1'b1) bad = 1'b1;
          @(negedge clk);
        end
        check("stall_hold", bad, 0);
        check("stall_rdata", rdata, sexp);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("stall_release", rvalid, 0);
      end
    join
    do_read(4'h0, "stall_next");

    // Randomized bursts, occasional bad stop bit, then drain
    for (int it = 0; it < 6; it++) begin
      nb = $urandom_range(1, 5);
      for (int k = 0; k < nb; k++) begin
        rb = 8'($urandom);
        send_byte(rb, ($urandom_range(0, 7) != 0));
      end
      check("rand_irq", rx_irq, 32'(mq.size() > 0));
      do_read(4'h4, "rand_status");
      n = mq.size();
      for (int k = 0; k <= n; k++) do_read(4'h0, "rand_rxdata");
    end

    // Reset during a stalled response and mid-frame (data bit 4)
    send_byte(8'h11, 1'b1);
    @(negedge clk);
    araddr = 4'h4; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    arvalid = 1'b0;
    check("pre_rst_rvalid", rvalid, 1);
    drive_frame(8'h77, 1'b1, 5);
    rx = 1'b1;                      // data bit 4 of 0x77
    repeat (BP / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_rvalid", rvalid, 0);
    check("midrst_arready", arready, 1);
    check("midrst_rdata", rdata, 0);
    check("midrst_irq", rx_irq, 0);
    mq.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (BP) @(negedge clk);
    send_byte(8'h77, 1'b1);
    do_read(4'h0, "post_rst_rxdata");
    do_read(4'h4, "post_rst_status");

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
